slt_share_arbiter: RTL and testbench

- Shares one 32-bit set-less-than compare unit among NREQ requesters, such as the ALU branch-compare path, the cache tag/LRU compare path and a debug port.
- Arbitrates round-robin, registers the granted operands, evaluates signed or unsigned less-than, and holds each 1-bit result in a per-requester response slot until that requester accepts it.
- Sits between requesting pipeline stages and the comparator datapath.

---
 rtl/slt_share_arbiter.sv | 130 +++++++++++++
 tb/tb_slt_share_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/slt_share_arbiter.sv
// Shared set-less-than unit: round-robin grant over NREQ requesters, one
// registered compare stage, and a per-requester result slot held until drained.
module slt_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_unsigned,
  output logic [NREQ-1:0]   resp_valid,
  output logic [NREQ-1:0]   resp_result,
  input  logic [NREQ-1:0]   resp_ready,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [IW-1:0] idx_t;

  // Stage S1 and the response slots
  logic            s1_valid;
  logic [W-1:0]    s1_a;
  logic [W-1:0]    s1_b;
  logic            s1_uns;
  idx_t            s1_idx;
  logic            s1_lt;
  idx_t            last_grant;
  logic [NREQ-1:0] slot_valid;
  logic [NREQ-1:0] slot_result;

  // Grant-side combinational signals
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  idx_t            grant_idx;
  logic            transfer;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            sel_uns;

  function automatic logic slt(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic uns);
    if (uns || (a[W-1] == b[W-1])) return (a < b);
    return a[W-1];
  endfunction

  // Eligibility only looks at registered state, so req_ready never depends
  // on resp_ready in the same cycle.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && !slot_valid[i] &&
                    !(s1_valid && (s1_idx == idx_t'(i)));
    end
  end

  always_comb begin
    idx_t cand;
    logic found;
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = idx_t'((int'(last_grant) + k) % NREQ);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign req_ready = reset ? '0 : grant;
  assign transfer  = |req_ready;

  // One-hot operand mux; grant is zero or one-hot, so OR-reduction is exact.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_uns = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a   = sel_a | ({W{grant[i]}} & req_a[i*W +: W]);
      sel_b   = sel_b | ({W{grant[i]}} & req_b[i*W +: W]);
      sel_uns = sel_uns | (grant[i] & req_unsigned[i]);
    end
  end

  assign s1_lt = slt(s1_a, s1_b, s1_uns);

  // Control state: S1 valid, round-robin pointer and slot flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    if (reset) begin
      s1_valid    <= 1'b0;
      last_grant  <= idx_t'(NREQ - 1);
      slot_valid  <= '0;
      slot_result <= '0;
    end else begin
      s1_valid <= transfer;
      if (transfer) last_grant <= grant_idx;
      for (int i = 0; i < NREQ; i++) begin
        if (s1_valid && (s1_idx == idx_t'(i))) begin
          slot_valid[i]  <= 1'b1;
          slot_result[i] <= s1_lt;
        end else if (slot_valid[i] && resp_ready[i]) begin
          slot_valid[i]  <= 1'b0;
        end
      end
    end
  end

  // NOTE: S1 payload is not reset; it is only observed while s1_valid is set.
  always_ff @(posedge clk) begin
    if (transfer) begin
      s1_a   <= sel_a;
      s1_b   <= sel_b;
      s1_uns <= sel_uns;
      s1_idx <= grant_idx;
    end
  end

  assign resp_valid  = slot_valid;
  assign resp_result = slot_result;
  assign busy        = s1_valid | (|slot_valid);

endmodule

// File: tb/tb_slt_share_arbiter.sv
// Directed bench for slt_share_arbiter: compare edge cases, round-robin order,
// back-pressure on one slot, reset mid-operation and idle behaviour.
module tb_slt_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_unsigned;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_result;
  logic [NREQ-1:0]   resp_ready;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  slt_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_unsigned(req_unsigned),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .resp_ready  (resp_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic uns);
    req_a[idx*W +: W]  = a;
    req_b[idx*W +: W]  = b;
    req_unsigned[idx]  = uns;
  endtask

  // Single requester, result held one extra cycle, then drained.
  task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic uns, input logic exp);
    set_op(idx, a, b, uns);
    req_valid  = 4'b0001 << idx;
    resp_ready = '0;
    settle();
    check("issue_grant", req_ready, 32'(4'b0001 << idx));
    tick();
    req_valid = '0;
    settle();
    check("s1_no_resp", resp_valid, 0);
    check("s1_busy", busy, 1);
    tick();
    settle();
    check("resp_valid_lat2", resp_valid, 32'(4'b0001 << idx));
    check("resp_result", resp_result[idx], exp);
    tick();
    settle();
    check("hold_valid", resp_valid, 32'(4'b0001 << idx));
    check("hold_result", resp_result[idx], exp);
    resp_ready = 4'b0001 << idx;
    tick();
    resp_ready = '0;
    settle();
    check("drained", resp_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  logic [NREQ-1:0] bp_seq [3];

  initial begin
    reset        = 1'b1;
    req_valid    = 4'hF;
    req_a        = '0;
    req_b        = '0;
    req_unsigned = '0;
    resp_ready   = '0;
    bp_seq[0]    = 4'b0100;
    bp_seq[1]    = 4'b1000;
    bp_seq[2]    = 4'b0001;

    // Reset state
    tick();
    tick();
    settle();
    check("rst_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_busy", busy, 0);
    reset     = 1'b0;
    req_valid = '0;
    settle();

    // Compare edge cases
    issue(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    issue(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    issue(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    issue(3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b1);
    issue(3, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
    issue(3, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1);

    // Round robin: last grant was 3, so order is 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i), 32'd2, 1'b1);
    resp_ready = 4'hF;
    req_valid  = 4'hF;
    settle();
    check("rr_c0", req_ready, 4'b0001);
    tick();
    settle();
    check("rr_c1", req_ready, 4'b0010);
    check("rr_busy1", busy, 1);
    tick();
    settle();
    check("rr_c2", req_ready, 4'b0100);
    check("rr_busy2", busy, 1);
    check("rr_resp0_valid", resp_valid[0], 1);
    check("rr_resp0_result", resp_result[0], 1);
    tick();
    settle();
    check("rr_c3", req_ready, 4'b1000);
    check("rr_busy3", busy, 1);
    tick();
    settle();
    check("rr_c4", req_ready, 4'b0001);
    check("rr_busy4", busy, 1);
    check("rr_resp2_valid", resp_valid[2], 1);
    check("rr_resp2_result", resp_result[2], 0);
    tick();
    req_valid = '0;
    settle();
    check("rr_stop", req_ready, 0);
    for (int i = 0; i < 4; i++) tick();
    settle();
    check("rr_idle_busy", busy, 0);

    // Back-pressure on requester 1; last grant is 0
    set_op(1, 32'h0, 32'h1, 1'b1);
    resp_ready = 4'b1101;
    req_valid  = 4'b0010;
    settle();
    check("bp_c0", req_ready, 4'b0010);
    tick();
    req_valid = 4'hF;
    for (int k = 1; k <= 12; k++) begin
      if (k == 12) resp_ready = 4'hF;
      settle();
      check("bp_grant", req_ready, 32'(bp_seq[(k-1)%3]));
      if (k >= 2) begin
        check("bp_hold_valid", resp_valid[1], 1);
        check("bp_hold_result", resp_result[1], 1);
      end
      tick();
    end
    settle();
    check("bp_regrant", req_ready, 4'b0010);
    check("bp_drained", resp_valid[1], 0);
    tick();
    req_valid = '0;
    for (int i = 0; i < 5; i++) tick();
    settle();
    check("bp_idle_busy", busy, 0);

    // Reset mid-operation; last grant is 1
    set_op(2, 32'h1, 32'h5, 1'b0);
    req_valid = 4'b0100;
    settle();
    check("rm_grant2", req_ready, 4'b0100);
    tick();
    reset     = 1'b1;
    req_valid = '0;
    settle();
    check("rm_ready_in_reset", req_ready, 0);
    tick();
    reset = 1'b0;
    settle();
    check("rm_resp_valid", resp_valid, 0);
    check("rm_busy", busy, 0);
    tick();
    settle();
    check("rm_no_late_resp", resp_valid, 0);
    check("rm_busy_late", busy, 0);
    req_valid = 4'hF;
    settle();
    check("rm_first_grant0", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    for (int i = 0; i < 4; i++) tick();
    settle();

    // No requests for 5 cycles, then a lone request from requester 3
    for (int k = 0; k < 5; k++) begin
      check("nr_ready", req_ready, 0);
      check("nr_busy", busy, 0);
      tick();
      settle();
    end
    issue(3, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
